// File: rtl/ebpf_pkg.sv
// Shared eBPF ALU encodings and the add/sub stage-1 payload type.
package ebpf_pkg;

  // Instruction class field op[2:0]
  localparam logic [2:0] CLASS_ALU   = 3'h4;
  localparam logic [2:0] CLASS_ALU64 = 3'h7;

  // Source select field op[3]
  typedef enum logic {
    SRC_K = 1'b0,
    SRC_X = 1'b1
  } src_e;

  // ALU operation code field op[7:4]
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_NEG = 4'h8;

  // Widest destination tag the payload can carry
  localparam int unsigned TAG_W_MAX = 16;

  // Operands and side info travelling through stage 1
  typedef struct packed {
    logic [63:0]          a;
    logic [63:0]          b;
    logic                 is32;
    logic [TAG_W_MAX-1:0] tag;
    logic                 err;
  } s1_payload_t;

  // Two's-complement negate, modulo 2^64
  function automatic logic [63:0] neg64(input logic [63:0] x);
    return (~x) + 64'd1;
  endfunction

  // Two's-complement negate, modulo 2^32
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

endpackage

// File: rtl/ebpf_addsub_operand_fmt.sv
// Decodes ADD/SUB/NEG opcodes and builds adder operands for the stage-1 register.
module ebpf_addsub_operand_fmt
  import ebpf_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic [7:0]       i_opcode,
  input  logic [63:0]      i_dst,
  input  logic [63:0]      i_src,
  input  logic [31:0]      i_imm,
  input  logic [TAG_W-1:0] i_tag,
  output s1_payload_t      o_payload
);

  logic [2:0]  w_cls;
  logic [3:0]  w_code;
  logic        w_is32;
  logic        w_legal;
  logic [63:0] w_s_full;
  logic [63:0] w_d;
  logic [63:0] w_s;
  logic [63:0] w_neg_d;
  logic [63:0] w_neg_s;

  // Field split, source select and ALU32 truncation
  always_comb begin
    w_cls    = i_opcode[2:0];
    w_code   = i_opcode[7:4];
    w_is32   = (w_cls == CLASS_ALU);
    w_s_full = (src_e'(i_opcode[3]) == SRC_X) ? i_src : {{32{i_imm[31]}}, i_imm};
    w_legal  = ((w_cls == CLASS_ALU) || (w_cls == CLASS_ALU64)) &&
               ((w_code == ALU_ADD) || (w_code == ALU_SUB) || (w_code == ALU_NEG));
    if (w_is32) begin
      w_d     = {32'h0, i_dst[31:0]};
      w_s     = {32'h0, w_s_full[31:0]};
      w_neg_d = {32'h0, neg32(i_dst[31:0])};
      w_neg_s = {32'h0, neg32(w_s_full[31:0])};
    end else begin
      w_d     = i_dst;
      w_s     = w_s_full;
      w_neg_d = neg64(i_dst);
      w_neg_s = neg64(w_s_full);
    end
  end

  // Operand pair selection per operation; illegal ops feed 0 + 0
  always_comb begin
    o_payload      = '0;
    o_payload.is32 = w_is32;
    o_payload.tag  = TAG_W_MAX'(i_tag);
    if (!w_legal) begin
      o_payload.err = 1'b1;
    end else begin
      case (w_code)
        ALU_SUB: begin
          o_payload.a = w_d;
          o_payload.b = w_neg_s;
        end
        ALU_NEG: begin
          o_payload.a = '0;
          o_payload.b = w_neg_d;
        end
        default: begin
          o_payload.a = w_d;
          o_payload.b = w_s;
        end
      endcase
    end
  end

endmodule

// File: rtl/ebpf_addsub_stage.sv
// Two-stage ADD/SUB/NEG pipeline around an external 64-bit combinational adder.
module ebpf_addsub_stage
  import ebpf_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_opcode,
  input  logic [63:0]      in_dst,
  input  logic [63:0]      in_src,
  input  logic [31:0]      in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      add_a,
  output logic [63:0]      add_b,
  input  logic [63:0]      add_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  s1_payload_t      w_fmt;
  s1_payload_t      r_s1;
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [63:0]      r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_err;
  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_accept;

  ebpf_addsub_operand_fmt #(
    .TAG_W (TAG_W)
  ) u_fmt (
    .i_opcode  (in_opcode),
    .i_dst     (in_dst),
    .i_src     (in_src),
    .i_imm     (in_imm),
    .i_tag     (in_tag),
    .o_payload (w_fmt)
  );

  // Handshake: a stage may load when its successor is empty or draining
  always_comb begin
    w_s2_adv = !r_s2_valid || out_ready;
    w_s1_adv = r_s1_valid && w_s2_adv;
    in_ready = !rst && (!r_s1_valid || w_s2_adv);
    w_accept = in_valid && in_ready;
  end

  // Stage 1: operand register; keeps last operands when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1 <= w_fmt;
      end
      r_s1_valid <= w_accept || (r_s1_valid && !w_s2_adv);
    end
  end

  // Stage 2: capture adder sum, zero-extending ALU32 results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_tag      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_result <= r_s1.is32 ? {32'h0, add_c[31:0]} : add_c;
        r_tag    <= TAG_W'(r_s1.tag);
        r_err    <= r_s1.err;
      end
      r_s2_valid <= w_s1_adv || (r_s2_valid && !out_ready);
    end
  end

  // Output drive
  always_comb begin
    add_a      = r_s1.a;
    add_b      = r_s1.b;
    out_valid  = r_s2_valid;
    out_result = r_result;
    out_tag    = r_tag;
    out_err    = r_err;
  end

endmodule
